// File: rtl/stuff_writer.sv
// Inventory record store for the vending machine: applies vend/restock/bulk-load updates
// and streams a frozen snapshot of all records to a ready/valid sink on request.
module stuff_writer #(
  parameter int NUM_ITEMS = 8,
  parameter int WIDTH     = 11,
  parameter int CNT_MAX   = 15
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_en,
  input  logic [NUM_ITEMS*WIDTH-1:0] load_data,
  input  logic                       vend_en,
  input  logic [$clog2(NUM_ITEMS)-1:0] vend_idx,
  output logic                       vend_ok,
  output logic                       vend_fail,
  input  logic                       restock_en,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_idx,
  input  logic [3:0]                 restock_qty,
  input  logic                       dump_start,
  output logic                       dump_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_ITEMS)-1:0] out_idx,
  output logic                       out_last,
  output logic                       dump_done
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int CNT_W = 4;
  localparam logic [CNT_W:0]   SAT  = (CNT_W+1)'(CNT_MAX);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ITEMS - 1);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic                    snap_load;
  logic [WIDTH-1:0]        rec      [NUM_ITEMS];
  logic [WIDTH-1:0]        rec_next [NUM_ITEMS];
  logic [WIDTH-1:0]        snap     [NUM_ITEMS];
  logic [CNT_W-1:0]        cnt;
  logic                    ok_next, fail_next;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > SAT) return SAT[CNT_W-1:0];
    return s[CNT_W-1:0];
  endfunction

  // Restock is folded in before vend so a same-index pair vends from the restocked count.
  always_comb begin
    rec_next  = rec;
    cnt       = '0;
    ok_next   = 1'b0;
    fail_next = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      cnt = rec[i][CNT_W-1:0];
      if (restock_en && restock_idx == IDX_W'(i))
        cnt = sat_add(cnt, restock_qty);
      if (vend_en && vend_idx == IDX_W'(i)) begin
        if (cnt != '0) begin
          cnt     = cnt - 1'b1;
          ok_next = 1'b1;
        end else begin
          fail_next = 1'b1;
        end
      end
      rec_next[i] = {rec[i][WIDTH-1:CNT_W], cnt};
    end
    if (load_en) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        rec_next[i] = load_data[i*WIDTH +: WIDTH];
      ok_next   = 1'b0;
      fail_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    snap_load  = 1'b0;
    case (state)
      IDLE: if (dump_start) begin
        state_next = DUMP;
        idx_next   = '0;
        snap_load  = 1'b1;
      end
      DUMP: if (out_ready) begin
        if (idx == LAST) state_next = DONE;
        else             idx_next   = idx + 1'b1;
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      vend_ok   <= 1'b0;
      vend_fail <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        rec[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      vend_ok   <= ok_next;
      vend_fail <= fail_next;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        rec[i] <= rec_next[i];
        // Snapshot takes the pre-update values of the dump_start cycle.
        if (snap_load) snap[i] <= rec[i];
      end
    end
  end

  assign out_valid = (state == DUMP);
  assign out_data  = out_valid ? snap[idx] : '0;
  assign out_idx   = out_valid ? idx : '0;
  assign out_last  = out_valid && (idx == LAST);
  assign dump_done = (state == DONE);
  assign dump_busy = (state != IDLE);

endmodule

// File: tb/tb_stuff_writer.sv
// Directed self-checking bench for stuff_writer: load, vend/restock rules, dump streaming,
// stalls, and reset during a dump.
module tb_stuff_writer;
  localparam int N = 8;
  localparam int W = 11;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           load_en;
  logic [N*W-1:0] load_data;
  logic           vend_en;
  logic [2:0]     vend_idx;
  logic           vend_ok, vend_fail;
  logic           restock_en;
  logic [2:0]     restock_idx;
  logic [3:0]     restock_qty;
  logic           dump_start;
  logic           dump_busy;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_idx;
  logic           out_last;
  logic           dump_done;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] expv [N];

  stuff_writer #(.NUM_ITEMS(N), .WIDTH(W), .CNT_MAX(15)) dut (
    .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_data(load_data),
    .vend_en(vend_en), .vend_idx(vend_idx), .vend_ok(vend_ok), .vend_fail(vend_fail),
    .restock_en(restock_en), .restock_idx(restock_idx), .restock_qty(restock_qty),
    .dump_start(dump_start), .dump_busy(dump_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .dump_done(dump_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int price, input int count);
    return {7'(price), 4'(count)};
  endfunction

  task automatic load_expv();
    for (int i = 0; i < N; i++) load_data[i*W +: W] = expv[i];
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  // Full-speed dump compared against expv.
  task automatic dump_check(input string tag);
    dump_start = 1'b1;
    out_ready  = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_busy"},  32'(dump_busy), 1);
      chk({tag, "_idx"},   32'(out_idx),   32'(k));
      chk({tag, "_data"},  32'(out_data),  32'(expv[k]));
      chk({tag, "_last"},  32'(out_last),  32'(k == N-1));
      chk({tag, "_nodone"}, 32'(dump_done), 0);
      tick();
    end
    chk({tag, "_done"},      32'(dump_done), 1);
    chk({tag, "_done_nval"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(dump_done), 0);
    chk({tag, "_idle_nval"},  32'(out_valid), 0);
  endtask

  initial begin
    reset_n = 1'b0; load_en = 0; load_data = '0; vend_en = 0; vend_idx = 0;
    restock_en = 0; restock_idx = 0; restock_qty = 0; dump_start = 0; out_ready = 0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_busy",  32'(dump_busy), 0);
    chk("rst_done",  32'(dump_done), 0);
    chk("rst_ok",    32'(vend_ok),   0);
    chk("rst_fail",  32'(vend_fail), 0);
    reset_n = 1'b1;
    tick();

    // 1: load {price=i+1, count=3} and stream it out
    for (int i = 0; i < N; i++) expv[i] = mk(i+1, 3);
    load_expv();
    dump_check("t1");

    // 2-4 share one load: idx1 count 0, idx2 count 0, idx3 count 12
    expv[1] = mk(2, 0); expv[2] = mk(3, 0); expv[3] = mk(4, 12);
    load_expv();
    vend_en = 1; vend_idx = 2;
    tick();
    vend_en = 0;
    chk("t2_fail", 32'(vend_fail), 1);
    chk("t2_nok",  32'(vend_ok),   0);
    tick();
    chk("t2_fail_pulse", 32'(vend_fail), 0);
    restock_en = 1; restock_idx = 2; restock_qty = 5;
    tick();
    restock_en = 0;
    vend_en = 1; vend_idx = 2;
    tick();
    vend_en = 0;
    chk("t2_ok",    32'(vend_ok),   1);
    chk("t2_nfail", 32'(vend_fail), 0);
    restock_en = 1; restock_idx = 3; restock_qty = 9;
    tick();
    restock_en = 1; restock_idx = 1; restock_qty = 2;
    vend_en = 1; vend_idx = 1;
    tick();
    chk("t4_same_ok", 32'(vend_ok), 1);
    restock_idx = 5; restock_qty = 1;
    vend_idx = 0;
    tick();
    restock_en = 0; vend_en = 0;
    chk("t4_diff_ok", 32'(vend_ok), 1);
    expv[0] = mk(1, 2); expv[1] = mk(2, 1); expv[2] = mk(3, 4);
    expv[3] = mk(4, 15); expv[5] = mk(6, 4);
    dump_check("t234");

    // 4b: load overrides a same-cycle vend, no pulse
    for (int i = 0; i < N; i++) expv[i] = mk(i+9, i+1);
    vend_en = 1; vend_idx = 0;
    load_expv();
    vend_en = 0;
    chk("t4_load_nok",   32'(vend_ok),   0);
    chk("t4_load_nfail", 32'(vend_fail), 0);
    dump_check("t4b");

    // 5: stalled dump with a mid-stream vend and a spurious dump_start
    begin
      int  e;
      bit  fin;
      e = 0; fin = 0;
      dump_start = 1;
      tick();
      dump_start = 0;
      for (int c = 0; c < 32 && !fin; c++) begin
        out_ready = (c % 2 == 0);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_idx",   32'(out_idx),   32'(e));
        chk("t5_data",  32'(out_data),  32'(expv[e]));
        chk("t5_last",  32'(out_last),  32'(e == N-1));
        vend_en = (c == 1); vend_idx = 0;
        dump_start = (c == 1);
        tick();
        if (c == 1) chk("t5_vend_ok", 32'(vend_ok), 1);
        if (out_ready) begin
          if (e == N-1) fin = 1;
          else e++;
        end
      end
      vend_en = 0; dump_start = 0;
      chk("t5_finished", 32'(fin), 1);
      chk("t5_done", 32'(dump_done), 1);
      tick();
      chk("t5_idle", 32'(out_valid), 0);
      chk("t5_idle_busy", 32'(dump_busy), 0);
    end
    expv[0] = mk(9, 0);
    dump_check("t5post");

    // 6: reset at out_idx 4 aborts the stream
    dump_start = 1; out_ready = 1;
    tick();
    dump_start = 0;
    repeat (4) tick();
    chk("t6_idx4", 32'(out_idx), 4);
    reset_n = 0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_idx",   32'(out_idx),   0);
    chk("t6_data",  32'(out_data),  0);
    chk("t6_last",  32'(out_last),  0);
    chk("t6_busy",  32'(dump_busy), 0);
    tick();
    chk("t6_nodone", 32'(dump_done), 0);
    reset_n = 1;
    tick();
    chk("t6_nodone2", 32'(dump_done), 0);
    for (int i = 0; i < N; i++) expv[i] = '0;
    dump_check("t6post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
